// File: rtl/rtype_sequencer_if.sv
// Datapath-side bundle of the R-type sequencer: the instruction word in, and the
// decoded ALU select, register addresses and write/PC strobes out.
interface rtype_sequencer_if #(
    parameter int addr_data_width = 32
);
    logic [addr_data_width-1:0] instr;
    logic [3:0]                 alu_op;
    logic [4:0]                 rd_addr;
    logic [4:0]                 rs1_addr;
    logic [4:0]                 rs2_addr;
    logic                       regfile_write_enable;
    logic                       pc_en;

    modport master (
        input  instr,
        output alu_op, rd_addr, rs1_addr, rs2_addr, regfile_write_enable, pc_en
    );

    modport slave (
        output instr,
        input  alu_op, rd_addr, rs1_addr, rs2_addr, regfile_write_enable, pc_en
    );
endinterface

// File: rtl/rtype_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the RV32I R-type datapath;
// halts on anything that is not a legal R-type instruction.
module rtype_sequencer #(
    parameter int addr_data_width = 32,
    parameter int COUNT_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               clear_halt,
    rtype_sequencer_if.master  dp,
    output logic               busy,
    output logic               halted,
    output logic               illegal_instr,
    output logic [COUNT_W-1:0] retired_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic [addr_data_width-1:0] ir;
    logic [3:0]                 alu_op_q;
    logic                       we_q;
    logic                       pc_en_q;
    logic                       legal;
    logic [3:0]                 op_dec;

    always_comb begin
        legal  = 1'b0;
        op_dec = '0;
        if (ir[6:0] == 7'b0110011) begin
            if (ir[31:25] == 7'b0000000) begin
                legal = 1'b1;
                case (ir[14:12])
                    3'b000:  op_dec = 4'b0000;
                    3'b001:  op_dec = 4'b0010;
                    3'b010:  op_dec = 4'b0011;
                    3'b011:  op_dec = 4'b0100;
                    3'b100:  op_dec = 4'b0101;
                    3'b101:  op_dec = 4'b0110;
                    3'b110:  op_dec = 4'b1000;
                    default: op_dec = 4'b1001;
                endcase
            end else if (ir[31:25] == 7'b0100000) begin
                if (ir[14:12] == 3'b000) begin
                    legal  = 1'b1;
                    op_dec = 4'b0001;
                end else if (ir[14:12] == 3'b101) begin
                    legal  = 1'b1;
                    op_dec = 4'b0111;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (run || step) state_nx = S_FETCH;
            S_FETCH:     state_nx = S_DECODE;
            S_DECODE:    state_nx = legal ? S_EXECUTE : S_HALT;
            S_EXECUTE:   state_nx = S_WRITEBACK;
            S_WRITEBACK: state_nx = run ? S_FETCH : S_IDLE;
            S_HALT:      if (clear_halt) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Strobes and status flags are registered from the next state so each one is
    // aligned with the state it describes and never sees an input combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            ir            <= '0;
            alu_op_q      <= '0;
            we_q          <= 1'b0;
            pc_en_q       <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            illegal_instr <= 1'b0;
            retired_count <= '0;
        end else begin
            state   <= state_nx;
            busy    <= (state_nx inside {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK});
            halted  <= (state_nx == S_HALT);
            pc_en_q <= (state_nx == S_WRITEBACK);
            we_q    <= (state_nx == S_WRITEBACK) && (ir[11:7] != 5'd0);
            if (state == S_FETCH)
                ir <= dp.instr;
            if (state == S_DECODE && legal)
                alu_op_q <= op_dec;
            if (state == S_WRITEBACK)
                retired_count <= retired_count + 1'b1;
            if (state == S_DECODE && !legal)
                illegal_instr <= 1'b1;
            else if (state == S_HALT && clear_halt)
                illegal_instr <= 1'b0;
        end
    end

    assign dp.alu_op               = alu_op_q;
    assign dp.rd_addr              = ir[11:7];
    assign dp.rs1_addr             = ir[19:15];
    assign dp.rs2_addr             = ir[24:20];
    assign dp.regfile_write_enable = we_q;
    assign dp.pc_en                = pc_en_q;
endmodule

// File: tb/tb_rtype_sequencer.sv
// Bench for rtype_sequencer: directed scenarios plus randomized R-type traffic,
// checked against a table-driven model of the instruction set and cycle timing.
module tb_rtype_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic        clear_halt;
    logic [31:0] instr;
    logic        busy_a, halted_a, ill_a;
    logic [31:0] cnt_a;
    logic        busy_b, halted_b, ill_b;
    logic [1:0]  cnt_b;

    int unsigned n_pass    = 0;
    int unsigned n_total   = 0;
    int unsigned n_fail    = 0;
    int unsigned model_cnt = 0;

    typedef struct packed {
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] code;
    } op_t;

    // ISA table: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
    op_t ops [10] = '{
        '{7'h00, 3'b000, 4'd0}, '{7'h20, 3'b000, 4'd1}, '{7'h00, 3'b001, 4'd2},
        '{7'h00, 3'b010, 4'd3}, '{7'h00, 3'b011, 4'd4}, '{7'h00, 3'b100, 4'd5},
        '{7'h00, 3'b101, 4'd6}, '{7'h20, 3'b101, 4'd7}, '{7'h00, 3'b110, 4'd8},
        '{7'h00, 3'b111, 4'd9}
    };

    always #5 clk = ~clk;

    rtype_sequencer_if #(.addr_data_width(32)) bus_a ();
    rtype_sequencer_if #(.addr_data_width(32)) bus_b ();
    assign bus_a.instr = instr;
    assign bus_b.instr = instr;

    rtype_sequencer #(.addr_data_width(32), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .clear_halt(clear_halt),
        .dp(bus_a), .busy(busy_a), .halted(halted_a), .illegal_instr(ill_a),
        .retired_count(cnt_a)
    );

    rtype_sequencer #(.addr_data_width(32), .COUNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .run(run), .step(step), .clear_halt(clear_halt),
        .dp(bus_b), .busy(busy_b), .halted(halted_b), .illegal_instr(ill_b),
        .retired_count(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_decode(input logic [31:0] ins, output bit lg, output logic [3:0] code);
        lg   = 1'b0;
        code = 4'd0;
        if (ins[6:0] == 7'b0110011)
            for (int i = 0; i < 10; i++)
                if (ops[i].f7 == ins[31:25] && ops[i].f3 == ins[14:12]) begin
                    lg   = 1'b1;
                    code = ops[i].code;
                end
    endtask

    function automatic logic [31:0] rand_instr(input bit want_legal);
        op_t         o;
        logic [31:0] r;
        logic [31:0] ins;
        logic [6:0]  f7;
        logic [2:0]  bad_f3 [6];
        bad_f3 = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
        o   = ops[$urandom_range(9)];
        r   = $urandom;
        ins = {o.f7, r[24:20], r[19:15], o.f3, r[11:7], 7'b0110011};
        if (!want_legal) begin
            case ($urandom_range(2))
                0: ins[6:0] = ins[6:0] ^ (r[31:25] | 7'h01);
                1: begin
                    ins[31:25] = 7'h20;
                    ins[14:12] = bad_f3[$urandom_range(5)];
                end
                default: begin
                    f7 = r[31:25];
                    if (f7 == 7'h00 || f7 == 7'h20) f7 = 7'h01;
                    ins[31:25] = f7;
                end
            endcase
        end
        return ins;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_busy_w"}, busy_b, 0);
        check({tag, "_halted"}, halted_a, 0);
        check({tag, "_pc_en"}, bus_a.pc_en, 0);
        check({tag, "_we"}, bus_a.regfile_write_enable, 0);
        check({tag, "_cnt"}, cnt_a, model_cnt);
    endtask

    task automatic check_zero(input string tag);
        check_idle(tag);
        check({tag, "_ill"}, ill_a, 0);
        check({tag, "_alu_op"}, bus_a.alu_op, 0);
        check({tag, "_rd"}, bus_a.rd_addr, 0);
        check({tag, "_rs1"}, bus_a.rs1_addr, 0);
        check({tag, "_rs2"}, bus_a.rs2_addr, 0);
        check({tag, "_cnt_w"}, cnt_b, 0);
    endtask

    // Caller arranges that the next edge enters FETCH; returns in WRITEBACK, or in HALT.
    task automatic do_instr(input logic [31:0] ins, input bit use_step, input bit drop_run,
                            output bit was_legal);
        bit         lg;
        logic [3:0] code;
        model_decode(ins, lg, code);
        was_legal = lg;
        instr     = ins;
        if (use_step) step = 1'b1;
        tick();
        step = 1'b0;
        check("fetch_busy", busy_a, 1);
        check("fetch_pc_en", bus_a.pc_en, 0);
        check("fetch_we", bus_a.regfile_write_enable, 0);
        check("fetch_cnt", cnt_a, model_cnt);
        check("fetch_cnt_wrap", cnt_b, model_cnt % 4);
        tick();
        check("decode_busy", busy_a, 1);
        check("decode_pc_en", bus_a.pc_en, 0);
        check("decode_rd", bus_a.rd_addr, ins[11:7]);
        check("decode_rs1", bus_a.rs1_addr, ins[19:15]);
        check("decode_rs2", bus_a.rs2_addr, ins[24:20]);
        tick();
        if (!lg) begin
            check("halt_halted", halted_a, 1);
            check("halt_ill", ill_a, 1);
            check("halt_busy", busy_a, 0);
            check("halt_pc_en", bus_a.pc_en, 0);
            check("halt_we", bus_a.regfile_write_enable, 0);
            return;
        end
        check("exec_alu_op", bus_a.alu_op, code);
        check("exec_pc_en", bus_a.pc_en, 0);
        check("exec_we", bus_a.regfile_write_enable, 0);
        if (drop_run) run = 1'b0;
        tick();
        check("wb_busy", busy_a, 1);
        check("wb_alu_op", bus_a.alu_op, code);
        check("wb_pc_en", bus_a.pc_en, 1);
        check("wb_we", bus_a.regfile_write_enable, ins[11:7] != 5'd0);
        check("wb_cnt", cnt_a, model_cnt);
        model_cnt++;
    endtask

    task automatic leave_halt();
        run  = 1'b0;
        step = 1'b0;
        clear_halt = 1'b1;
        tick();
        clear_halt = 1'b0;
        check("clear_ill", ill_a, 0);
        check_idle("cleared");
    endtask

    initial begin
        bit lg;
        int unsigned burst;
        reset = 1'b0; run = 1'b0; step = 1'b0; clear_halt = 1'b0; instr = '0;
        tick();
        tick();
        check_zero("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_zero("idle");
        end

        // ADD x3,x1,x2 by step
        do_instr(32'h002081B3, 1'b1, 1'b0, lg);
        tick();
        check_idle("after_add");

        // SUB x0 then SRA under run, run dropped during SRA's EXECUTE
        run = 1'b1;
        do_instr(32'h40208033, 1'b0, 1'b0, lg);
        do_instr(32'h4020D033, 1'b0, 1'b1, lg);
        tick();
        check_idle("after_run");

        // ADDI is illegal; run/step ignored in HALT
        do_instr(32'h00000013, 1'b1, 1'b0, lg);
        run  = 1'b1;
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold", halted_a, 1);
            check("halt_hold_busy", busy_a, 0);
            check("halt_hold_cnt", cnt_a, model_cnt);
        end
        leave_halt();

        // clear_halt outside HALT and step during WRITEBACK are both ignored
        clear_halt = 1'b1;
        tick();
        clear_halt = 1'b0;
        check_idle("idle_clear");
        do_instr(32'h0020F2B3, 1'b1, 1'b0, lg);
        step = 1'b1;
        tick();
        step = 1'b0;
        check_idle("wb_step_ignored");

        // randomized traffic, mixing step and run bursts
        for (int it = 0; it < 40; it++) begin
            bit by_step;
            by_step = ($urandom_range(1) == 1);
            burst   = by_step ? 1 : $urandom_range(1, 3);
            if (!by_step) run = 1'b1;
            for (int k = 0; k < int'(burst); k++) begin
                do_instr(rand_instr($urandom_range(4) != 0), by_step && k == 0,
                         k == int'(burst) - 1, lg);
                if (!lg) break;
            end
            if (!lg) begin
                leave_halt();
            end else begin
                tick();
                check_idle("rand_end");
            end
        end

        // reset during EXECUTE aborts immediately
        instr = 32'h002081B3;
        step  = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        #1 reset = 1'b0;
        #1;
        model_cnt = 0;
        check_zero("async_reset");
        tick();
        check_zero("reset_held");
        reset = 1'b1;
        tick();
        check_zero("reset_released");

        // five retirements: the 2-bit counter wraps to 1
        for (int i = 0; i < 5; i++) begin
            do_instr(rand_instr(1'b1), 1'b1, 1'b0, lg);
            tick();
        end
        check("wrap_cnt", cnt_b, model_cnt % 4);
        check("full_cnt", cnt_a, model_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
